// File: rtl/fft8_pkg.sv
// Shared types and helpers for the 8-point FFT frame sequencer.
// The full-width magnitude helper accepts operands up to 16 bits wide.
package fft8_pkg;
  localparam int N_PTS      = 8;
  localparam int LOG2_N     = 3;
  localparam int DATA_W_DEF = 8;
  localparam int RES_W_DEF  = 9;
  localparam int MAG_ARG_W  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    CAPT   = 3'd4,
    DRAIN  = 3'd5
  } seq_state_t;

  // re*re + im*im; the sum is nonnegative, so it is returned as unsigned
  function automatic logic [2*MAG_ARG_W-1:0] mag_full(input logic signed [MAG_ARG_W-1:0] re,
                                                      input logic signed [MAG_ARG_W-1:0] im);
    logic signed [2*MAG_ARG_W-1:0] re_sq;
    logic signed [2*MAG_ARG_W-1:0] im_sq;
    re_sq = re * re;
    im_sq = im * im;
    return $unsigned(re_sq) + $unsigned(im_sq);
  endfunction
endpackage

// File: rtl/fft8_mag_unit.sv
// Squared magnitude of one FFT bin, reduced to OUT_W bits.
// Define FFT_SEQ_MAG_SAT_EN to saturate instead of wrapping.
module fft8_mag_unit
  import fft8_pkg::*;
#(
  parameter int RES_W = RES_W_DEF,
  parameter int OUT_W = 9
) (
  input  logic signed [RES_W-1:0] re,
  input  logic signed [RES_W-1:0] im,
  output logic        [OUT_W-1:0] mag
);
  localparam int FULL_W = 2 * RES_W;

  logic [2*MAG_ARG_W-1:0] wide_s;
  logic [FULL_W-1:0]      full_s;

  assign wide_s = mag_full({{(MAG_ARG_W-RES_W){re[RES_W-1]}}, re},
                           {{(MAG_ARG_W-RES_W){im[RES_W-1]}}, im});
  assign full_s = wide_s[FULL_W-1:0];

`ifdef FFT_SEQ_MAG_SAT_EN
  localparam logic [FULL_W-1:0] SAT_MAX = {{(FULL_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  logic unused_s;
  assign unused_s = ^wide_s[2*MAG_ARG_W-1:FULL_W];

  // Clamp to the largest representable magnitude
  always_comb begin
    if (full_s > SAT_MAX) begin
      mag = {OUT_W{1'b1}};
    end else begin
      mag = full_s[OUT_W-1:0];
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{wide_s[2*MAG_ARG_W-1:FULL_W], full_s[FULL_W-1:OUT_W]};

  // Keep only the low OUT_W bits
  always_comb begin
    mag = full_s[OUT_W-1:0];
  end
`endif
endmodule

// File: rtl/fft8_frame_sequencer.sv
// Collects an 8-sample frame, launches the FFT core, captures its bins and
// streams squared magnitudes. Optional build macro: FFT_SEQ_MAG_SAT_EN.
module fft8_frame_sequencer
  import fft8_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int FFT_LAT = 3,
  parameter int OUT_W   = 9
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  output logic [N_PTS*DATA_W-1:0]   fft_x,
  output logic                      fft_start,
  input  logic [N_PTS*RES_W-1:0]    fft_re,
  input  logic [N_PTS*RES_W-1:0]    fft_im,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LOG2_N-1:0]         out_bin,
  output logic [OUT_W-1:0]          out_mag,
  output logic                      busy,
  output logic                      frame_done
);
  localparam logic [3:0]        WAIT_INIT = 4'(FFT_LAT - 1);
  localparam logic [LOG2_N-1:0] LAST_IDX  = LOG2_N'(N_PTS - 1);

  seq_state_t                state_r;
  logic [LOG2_N-1:0]         ld_cnt_r;
  logic [LOG2_N-1:0]         dr_cnt_r;
  logic [3:0]                wait_cnt_r;
  logic [N_PTS*DATA_W-1:0]   frame_r;
  logic [N_PTS*RES_W-1:0]    buf_re_r;
  logic [N_PTS*RES_W-1:0]    buf_im_r;
  logic                      in_ready_r;
  logic                      fft_start_r;
  logic                      out_valid_r;
  logic [OUT_W-1:0]          out_mag_r;
  logic                      busy_r;
  logic                      frame_done_r;

  logic                      in_acc_s;
  logic                      out_hs_s;
  logic [LOG2_N-1:0]         sel_idx_s;
  logic [N_PTS*RES_W-1:0]    src_re_s;
  logic [N_PTS*RES_W-1:0]    src_im_s;
  logic signed [RES_W-1:0]   sel_re_s;
  logic signed [RES_W-1:0]   sel_im_s;
  logic [OUT_W-1:0]          mag_s;

  assign in_acc_s = in_valid && in_ready_r;
  assign out_hs_s = out_valid_r && out_ready;

  // Pick the bin whose magnitude will be presented next cycle; in CAPT the
  // buffer is still loading, so bin 0 is taken straight from the core.
  always_comb begin
    src_re_s  = buf_re_r;
    src_im_s  = buf_im_r;
    sel_idx_s = dr_cnt_r;
    if (state_r == CAPT) begin
      src_re_s  = fft_re;
      src_im_s  = fft_im;
      sel_idx_s = '0;
    end else if (out_hs_s) begin
      sel_idx_s = dr_cnt_r + LOG2_N'(1);
    end else begin
      sel_idx_s = dr_cnt_r;
    end
    sel_re_s = src_re_s[sel_idx_s*RES_W +: RES_W];
    sel_im_s = src_im_s[sel_idx_s*RES_W +: RES_W];
  end

  fft8_mag_unit #(
    .RES_W (RES_W),
    .OUT_W (OUT_W)
  ) u_mag (
    .re  (sel_re_s),
    .im  (sel_im_s),
    .mag (mag_s)
  );

  // Frame sequencing FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      ld_cnt_r     <= '0;
      dr_cnt_r     <= '0;
      wait_cnt_r   <= 4'd0;
      frame_r      <= '0;
      buf_re_r     <= '0;
      buf_im_r     <= '0;
      in_ready_r   <= 1'b1;
      fft_start_r  <= 1'b0;
      out_valid_r  <= 1'b0;
      out_mag_r    <= '0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      fft_start_r  <= 1'b0;
      frame_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_acc_s) begin
            frame_r[0 +: DATA_W] <= in_data;
            ld_cnt_r             <= LOG2_N'(1);
            busy_r               <= 1'b1;
            state_r              <= LOAD;
          end
        end
        LOAD: begin
          if (in_acc_s) begin
            frame_r[ld_cnt_r*DATA_W +: DATA_W] <= in_data;
            if (ld_cnt_r == LAST_IDX) begin
              ld_cnt_r    <= '0;
              in_ready_r  <= 1'b0;
              fft_start_r <= 1'b1;
              state_r     <= LAUNCH;
            end else begin
              ld_cnt_r <= ld_cnt_r + LOG2_N'(1);
            end
          end
        end
        LAUNCH: begin
          wait_cnt_r <= WAIT_INIT;
          state_r    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt_r == 4'd0) begin
            state_r <= CAPT;
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        CAPT: begin
          buf_re_r    <= fft_re;
          buf_im_r    <= fft_im;
          dr_cnt_r    <= '0;
          out_valid_r <= 1'b1;
          out_mag_r   <= mag_s;
          state_r     <= DRAIN;
        end
        DRAIN: begin
          if (out_hs_s) begin
            if (dr_cnt_r == LAST_IDX) begin
              dr_cnt_r     <= '0;
              out_valid_r  <= 1'b0;
              out_mag_r    <= '0;
              in_ready_r   <= 1'b1;
              busy_r       <= 1'b0;
              frame_done_r <= 1'b1;
              state_r      <= IDLE;
            end else begin
              dr_cnt_r  <= dr_cnt_r + LOG2_N'(1);
              out_mag_r <= mag_s;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign fft_x      = frame_r;
  assign fft_start  = fft_start_r;
  assign out_valid  = out_valid_r;
  assign out_bin    = dr_cnt_r;
  assign out_mag    = out_mag_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
endmodule

// File: tb/tb_fft8_frame_sequencer.sv
// Self-checking bench: a stand-in FFT core plus a frame-level reference model
// compared against the sequencer on every cycle.
module tb_fft8_frame_sequencer;
  localparam int DW  = 8;
  localparam int RW  = 9;
  localparam int LAT = 3;
  localparam int OW  = 9;
`ifdef FFT_SEQ_MAG_SAT_EN
  localparam int DC_BIN0 = 511;
`else
  localparam int DC_BIN0 = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = 8'd0;
  logic [8*DW-1:0] fft_x;
  logic            fft_start;
  logic [8*RW-1:0] fft_re;
  logic [8*RW-1:0] fft_im;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [2:0]      out_bin;
  logic [OW-1:0]   out_mag;
  logic            busy;
  logic            frame_done;

  always #5 clk = ~clk;

  fft8_frame_sequencer #(.DATA_W(DW), .RES_W(RW), .FFT_LAT(LAT), .OUT_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .fft_x(fft_x), .fft_start(fft_start), .fft_re(fft_re), .fft_im(fft_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin), .out_mag(out_mag),
    .busy(busy), .frame_done(frame_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Rounded 8-point DFT of real samples, each bin wrapped to RW bits
  function automatic logic [71:0] dft(input logic [63:0] x, input bit imag);
    logic [71:0] r;
    real acc;
    real ang;
    int v;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      acc = 0.0;
      for (int n = 0; n < 8; n++) begin
        ang = 2.0 * 3.14159265358979 * real'(k * n) / 8.0;
        if (imag) acc = acc - real'(x[n*8 +: 8]) * $sin(ang);
        else      acc = acc + real'(x[n*8 +: 8]) * $cos(ang);
      end
      v = $rtoi($floor(acc + 0.5));
      r[k*9 +: 9] = v[8:0];
    end
    return r;
  endfunction

  function automatic int exp_mag(input logic signed [8:0] re, input logic signed [8:0] im);
    int full;
    full = int'(re) * int'(re) + int'(im) * int'(im);
`ifdef FFT_SEQ_MAG_SAT_EN
    return (full > 511) ? 511 : full;
`else
    return full % 512;
`endif
  endfunction

  // Stand-in core: results appear LAT cycles after fft_start, junk before
  int          age = 0;
  logic [71:0] res_re = '0;
  logic [71:0] res_im = '0;
  always @(posedge clk) begin
    if (fft_start) begin
      res_re <= dft(fft_x, 1'b0);
      res_im <= dft(fft_x, 1'b1);
      age    <= 1;
    end else if (age != 0 && age < 20) begin
      age <= age + 1;
    end
  end
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      if (age >= LAT) begin
        fft_re[k*RW +: RW] = res_re[k*RW +: RW];
        fft_im[k*RW +: RW] = res_im[k*RW +: RW];
      end else begin
        fft_re[k*RW +: RW] = 9'h0a5 + 9'(k);
        fft_im[k*RW +: RW] = 9'h05a;
      end
    end
  end

  // Reference model state
  bit          mon_en = 1'b0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          lead = 0;
  int          out_idx = 0;
  bit          out_active = 1'b0;
  bit          exp_start = 1'b0;
  bit          exp_done = 1'b0;
  logic [63:0] samp = '0;
  int          exp_m [8];
  int          acc8_cyc = 0;
  int          start_cyc = 0;
  int          n_starts = 0;
  int          done_cycs [$];
  int          log_bin [$];
  int          log_mag [$];

  always @(negedge clk) begin
    int acc_old;
    logic [71:0] mre;
    logic [71:0] mim;
    cyc++;
    if (mon_en) begin
      chk("in_ready", in_ready, acc_cnt < 8);
      chk("busy", busy, acc_cnt != 0);
      chk("fft_start", fft_start, exp_start);
      chk("frame_done", frame_done, exp_done);
      chk("out_valid", out_valid, out_active);
      if (out_active) begin
        chk("out_bin", out_bin, out_idx);
        chk("out_mag", out_mag, exp_m[out_idx]);
      end
      if (acc_cnt == 8) chk("fft_x", fft_x, samp);
      if (fft_start) begin start_cyc = cyc; n_starts++; end
      if (frame_done) done_cycs.push_back(cyc);
      if (out_valid && out_ready) begin
        log_bin.push_back(int'(out_bin));
        log_mag.push_back(int'(out_mag));
      end
      acc_old = acc_cnt;
      if (!rst_n) begin
        acc_cnt = 0; lead = 0; out_idx = 0; out_active = 1'b0;
        exp_start = 1'b0; exp_done = 1'b0;
      end else begin
        exp_start = 1'b0;
        exp_done  = 1'b0;
        if (out_active && out_ready) begin
          if (out_idx == 7) begin
            out_active = 1'b0; exp_done = 1'b1; acc_cnt = 0;
          end else begin
            out_idx++;
          end
        end
        if (lead != 0) begin
          lead--;
          if (lead == 0) begin out_active = 1'b1; out_idx = 0; end
        end
        if (in_valid && acc_old < 8) begin
          samp[acc_old*8 +: 8] = in_data;
          acc_cnt = acc_old + 1;
          if (acc_cnt == 8) begin
            exp_start = 1'b1;
            lead      = LAT + 2;
            acc8_cyc  = cyc;
            mre = dft(samp, 1'b0);
            mim = dft(samp, 1'b1);
            for (int k = 0; k < 8; k++) exp_m[k] = exp_mag(mre[k*9 +: 9], mim[k*9 +: 9]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin chk("send_accept", in_ready, 1); break; end
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] f, input bit gaps);
    for (int i = 0; i < 8; i++) send(f[i*8 +: 8], gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (frame_done) break;
      t++;
      if (t > 300) begin chk("frame_done_timeout", frame_done, 1); break; end
    end
    tick();
  endtask

  task automatic clear_logs();
    log_bin.delete();
    log_mag.delete();
    done_cycs.delete();
  endtask

  initial begin
    logic [71:0] tmp;
    int s0;
    // Model pins
    chk("pin_mag_one", exp_mag(9'sd1, 9'sd0), 1);
    chk("pin_mag_dc", exp_mag(9'sd32, 9'sd0), DC_BIN0);
    tmp = dft(64'h0000_0000_0000_0001, 1'b0);
    chk("pin_dft_imp_re3", tmp[3*9 +: 9], 1);
    tmp = dft(64'h0404_0404_0404_0404, 1'b0);
    chk("pin_dft_dc_re0", tmp[0 +: 9], 32);
    chk("pin_dft_dc_re2", tmp[2*9 +: 9], 0);

    // Reset values
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fft_start", fft_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bin", out_bin, 0);
    chk("rst_out_mag", out_mag, 0);
    chk("rst_fft_x", fft_x, 0);
    chk("rst_frame_done", frame_done, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Impulse
    clear_logs();
    send_frame(64'h0000_0000_0000_0001, 1'b0);
    wait_done();
    chk("imp_start_lat", start_cyc - acc8_cyc, 1);
    chk("imp_count", log_mag.size(), 8);
    for (int i = 0; i < 8 && i < log_mag.size(); i++) begin
      chk("imp_bin", log_bin[i], i);
      chk("imp_mag", log_mag[i], 1);
    end
    chk("imp_done_pulses", done_cycs.size(), 1);

    // DC overflow
    clear_logs();
    send_frame(64'h0404_0404_0404_0404, 1'b0);
    wait_done();
    chk("dc_count", log_mag.size(), 8);
    if (log_mag.size() == 8) begin
      chk("dc_bin0", log_mag[0], DC_BIN0);
      for (int i = 1; i < 8; i++) chk("dc_binx", log_mag[i], 0);
    end

    // Backpressure at bin 3
    clear_logs();
    fork
      send_frame(64'h1020_3040_5060_7080, 1'b0);
      begin
        int t;
        t = 0;
        while (t < 300) begin
          tick();
          t++;
          if (out_valid && out_bin == 3'd3) break;
        end
        chk("bp_reach_bin3", out_bin, 3);
        out_ready = 1'b0;
        repeat (5) tick();
        chk("bp_hold_valid", out_valid, 1);
        out_ready = 1'b1;
      end
    join
    wait_done();
    chk("bp_count", log_mag.size(), 8);
    for (int i = 0; i < 8 && i < log_bin.size(); i++) chk("bp_order", log_bin[i], i);

    // Input gaps, then traffic on in_valid while the frame is in flight
    clear_logs();
    send_frame(64'h0908_0706_0504_0302, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'hee;
    repeat (LAT + 6) tick();
    in_valid = 1'b0;
    wait_done();
    chk("gap_count", log_mag.size(), 8);

    // Reset after 5 accepted samples
    for (int i = 0; i < 5; i++) send(8'(i + 10), 0);
    s0 = n_starts;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (4) tick();
    chk("mid_rst_no_start", n_starts, s0);
    clear_logs();
    send_frame(64'h2211_0099_8877_6655, 1'b0);
    wait_done();
    chk("mid_rst_count", log_mag.size(), 8);

    // Back-to-back frames
    clear_logs();
    send_frame(64'h0102_0304_0506_0708, 1'b0);
    send_frame(64'h0807_0605_0403_0201, 1'b0);
    wait_done();
    chk("b2b_count", log_mag.size(), 16);
    chk("b2b_done_pulses", done_cycs.size(), 2);
    if (done_cycs.size() == 2) chk("b2b_period", done_cycs[1] - done_cycs[0], 18 + LAT);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fft8_frame_sequencer.md
Name: fft8_frame_sequencer

Overview:
Controller that sequences the 8-point FFT datapath. It collects 8 real samples over a valid/ready stream and presents them as a frame to the FFT core. It then launches the core, waits a fixed latency, captures the bin results, and streams per-bin squared magnitude out over a second valid/ready stream. It sits between the chip-level I/O wrapper and the fft core, replacing ad-hoc free-running counter control.

Parameters:
DATA_W, 8, input sample width (unsigned real samples)
RES_W, 9, signed width of each FFT re/im result
FFT_LAT, 3, cycles from fft_start to valid results at fft core outputs (range 1..15)
OUT_W, 9, width of streamed magnitude

Ports:
clk  in  1  clock
rst_n  in  1  reset
in_valid  in  1  sample offered
in_ready  out  1  sequencer accepts sample
in_data  in  DATA_W  sample value
fft_x  out  8*DATA_W  frame to fft core; sample k at [k*DATA_W +: DATA_W]
fft_start  out  1  one-cycle launch pulse to fft core
fft_re  in  8*RES_W  core real results, bin k at [k*RES_W +: RES_W]
fft_im  in  8*RES_W  core imag results, same packing
out_valid  out  1  magnitude available
out_ready  in  1  downstream accepts
out_bin  out  3  bin index of out_mag
out_mag  out  OUT_W  squared magnitude of bin
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse after last bin accepted

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. Reset applies on the clk edge while rst_n=0.
- Reset values:
  - state=IDLE; all counters 0; fft_x=0; captured bins=0.
  - in_ready=1 (IDLE accepts immediately); fft_start=0; out_valid=0; out_bin=0; out_mag=0; busy=0; frame_done=0.
- States:
  - IDLE: in_ready=1. On the first accepted sample (in_valid&&in_ready), write slot 0, set ld_cnt=1, go to LOAD.
  - LOAD: in_ready=1. Each accept writes in_data into slot ld_cnt, then ld_cnt++. The accept that writes slot 7 goes to LAUNCH; in_ready drops on the next cycle.
  - LAUNCH: one cycle. fft_start=1, in_ready=0, wait_cnt loaded with FFT_LAT-1. Go to WAIT.
  - WAIT: decrement wait_cnt. When wait_cnt==0, go to CAPT. fft_x must be held stable from LAUNCH through CAPT.
  - CAPT: one cycle. Register all 16 re/im values into an internal bin buffer. Set dr_cnt=0 and go to DRAIN.
  - DRAIN: out_valid=1, out_bin=dr_cnt, out_mag=mag(buffer[dr_cnt]).
    - Hold out_bin/out_mag stable while out_valid&&!out_ready.
    - On handshake with dr_cnt!=7: dr_cnt++.
    - On handshake with dr_cnt==7: go to IDLE and pulse frame_done on the following cycle (frame_done aligned with the IDLE entry cycle).
- Latency: 8th-sample accept → fft_start is 1 cycle. fft_start → CAPT is FFT_LAT cycles. CAPT → first out_valid is 1 cycle. Minimum frame period is 8+1+FFT_LAT+1+8 cycles.
- Magnitude: mag = re*re + im*im on signed RES_W operands, computed at full width 2*RES_W. Result is nonnegative; max is 2*2^(2*(RES_W-1)). Reduction to OUT_W depends on the optional feature.
- in_valid gaps: LOAD holds in any state without a handshake; no timeout.
- Backpressure: out_ready low stalls DRAIN indefinitely. in_ready stays 0 throughout, so new samples are never overwritten mid-frame.
- Simultaneous events: in_valid is ignored while in_ready=0. out_ready is ignored while out_valid=0.
- Reset mid-operation, in any state: partial frame discarded, outputs return to reset values, and fft_start must not be issued.
- Counters are 3-bit and never wrap outside their defined transitions.

Optional Feature:
FFT_SEQ_MAG_SAT_EN
- Defined: out_mag = full mag saturated to 2^OUT_W-1 when it exceeds that value.
- Not defined: out_mag = full mag truncated to its low OUT_W bits (wrap).
- The full-width computation is identical in both builds; only the final reduction differs.

Decomposition:
- Package fft8_pkg: N_PTS=8, LOG2_N=3, default DATA_W/RES_W, the state enum (IDLE, LOAD, LAUNCH, WAIT, CAPT, DRAIN), and a function returning the full-width magnitude.
- One sub-module, fft8_mag_unit: combinational re/im → out_mag with the saturate/wrap option. It is instantiated once on the DRAIN mux output, not per bin.

Test Plan:
- Impulse: samples 1,0,0,0,0,0,0,0 with a behavioural FFT model at FFT_LAT=3 → fft_start exactly 1 cycle after the 8th accept; bins 0..7 each re=1, im=0 → out_mag=1 for out_bin 0..7 in order; frame_done pulse once.
- DC overflow: all samples 4 → bin0 re=32, full mag 1024, others 0.
  - With FFT_SEQ_MAG_SAT_EN: out_mag bin0 = 511.
  - Without: out_mag bin0 = 0 (1024 mod 512).
  - Remaining bins 0.
- Backpressure: out_ready low for 5 cycles at bin 3 → out_bin=3 and out_mag held stable, out_valid stays 1; then exactly 8 transfers total, no duplicates or skips.
- Input gaps plus protection: in_valid toggled randomly while loading → all 8 samples land in correct slots. in_valid asserted during WAIT/DRAIN → in_ready=0, fft_x unchanged.
- Reset mid-frame: rst_n low for 1 cycle after 5 accepted samples → busy=0, in_ready=1, no fft_start. The next 8 samples form a clean frame with correct results.
- Back-to-back frames: two frames streamed continuously with out_ready=1 → 16 outputs, two frame_done pulses, frame period = 18+FFT_LAT cycles.
